// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory line port between the
// instruction cache and the data cache; the granted side drives memory live.
module pmem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  i_grant_count,
    output logic [CNT_WIDTH-1:0]  d_grant_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t state, state_next;
    logic   last_grant_d;
    logic   req_i, req_d;
    logic   done_i, done_d;

    assign req_i = i_pmem_read;
    assign req_d = d_pmem_read | d_pmem_write;

    assign done_i = (state == GRANT_I) && mem_resp;
    assign done_d = (state == GRANT_D) && mem_resp;

    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;
    assign busy         = (state != IDLE);

    always_comb begin
        state_next  = state;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;
        unique case (state)
            IDLE: begin
                // Contention goes to whoever was not served last.
                if (req_i && req_d)
                    state_next = last_grant_d ? GRANT_I : GRANT_D;
                else if (req_i)
                    state_next = GRANT_I;
                else if (req_d)
                    state_next = GRANT_D;
            end
            GRANT_I: begin
                mem_read    = i_pmem_read;
                mem_address = i_pmem_address;
                if (mem_resp) begin
                    i_pmem_resp = 1'b1;
                    state_next  = IDLE;
                end
            end
            GRANT_D: begin
                mem_read    = d_pmem_read;
                mem_write   = d_pmem_write;
                mem_address = d_pmem_address;
                mem_wdata   = d_pmem_wdata;
                if (mem_resp) begin
                    d_pmem_resp = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant_d  <= 1'b1;
            i_grant_count <= '0;
            d_grant_count <= '0;
        end else begin
            state <= state_next;
            if (done_i) begin
                last_grant_d <= 1'b0;
                if (i_grant_count != '1)
                    i_grant_count <= i_grant_count + CNT_WIDTH'(1);
            end
            if (done_d) begin
                last_grant_d <= 1'b1;
                if (d_grant_count != '1)
                    d_grant_count <= d_grant_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: a per-cycle vector table plus hand-written
// sequences for reset, long waits, back-to-back traffic and counter saturation.
module tb_pmem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;
    localparam int unsigned CW = 4;

    localparam logic [AW-1:0] I_ADDR = 32'h0000_1000;
    localparam logic [AW-1:0] D_ADDR = 32'h0000_2000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;
    logic          busy;
    logic [CW-1:0] i_grant_count;
    logic [CW-1:0] d_grant_count;

    int compared   = 0;
    int mismatched = 0;

    logic [LW-1:0] wdata_pat;
    logic [LW-1:0] rdata_pat;

    pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp),
        .busy           (busy),
        .i_grant_count  (i_grant_count),
        .d_grant_count  (d_grant_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One table row = one clock cycle: inputs driven after the falling edge,
    // outputs checked 1ns later.
    typedef struct packed {
        logic [3:0]    in;    // {i_read, d_read, d_write, mem_resp}
        logic [1:0]    rw;    // expected {mem_read, mem_write}
        logic [AW-1:0] addr;  // expected mem_address
        logic [3:0]    flg;   // expected {wdata is dcache data, i_resp, d_resp, busy}
        logic [CW-1:0] ic;
        logic [CW-1:0] dc;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] in, input logic [1:0] rw, input logic [AW-1:0] addr,
                                input logic [3:0] flg, input logic [CW-1:0] ic, input logic [CW-1:0] dc);
        vec_t v;
        v.in = in; v.rw = rw; v.addr = addr; v.flg = flg; v.ic = ic; v.dc = dc;
        return v;
    endfunction

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
    } dop_t;

    typedef struct packed {
        logic          is_d;
        logic          wr;
        logic [AW-1:0] addr;
    } txn_t;

    dop_t dq[$];
    txn_t log_q[$];
    int   i_rem;

    task automatic drive_idle();
        i_pmem_read  = 1'b0;
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        mem_resp     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Cache models hold requests until resp; memory answers on the third
    // cycle a command is visible.
    task automatic run_traffic(input int budget);
        int wait_cnt = 0;
        int idle_run = 0;
        log_q.delete();
        for (int cyc = 0; cyc < budget && (i_rem > 0 || dq.size() > 0); cyc++) begin
            @(negedge clk);
            i_pmem_read    = (i_rem > 0);
            i_pmem_address = I_ADDR;
            if (dq.size() > 0) begin
                d_pmem_read    = ~dq[0].wr;
                d_pmem_write   = dq[0].wr;
                d_pmem_address = dq[0].addr;
            end else begin
                d_pmem_read  = 1'b0;
                d_pmem_write = 1'b0;
            end
            mem_resp = 1'b0;
            #1;
            if (mem_read || mem_write)
                mem_resp = (wait_cnt >= 2);
            #1;
            if (!busy) begin
                idle_run++;
            end else begin
                if (idle_run != 0)
                    check("idle_gap", 64'(idle_run), 64'd1);
                idle_run = 0;
            end
            if (mem_resp) begin
                check("resp_excl", 64'(i_pmem_resp ^ d_pmem_resp), 64'd1);
                log_q.push_back('{is_d: d_pmem_resp, wr: mem_write, addr: mem_address});
                if (i_pmem_resp) i_rem--;
                if (d_pmem_resp) void'(dq.pop_front());
                wait_cnt = 0;
            end else if (mem_read || mem_write) begin
                wait_cnt++;
            end
        end
        check("traffic_done", 64'(i_rem == 0 && dq.size() == 0), 64'd1);
        @(negedge clk);
        drive_idle();
        #1;
    endtask

    initial begin
        vec_t tbl[15];
        logic [AW-1:0] exp_addr[3];
        logic          exp_wr[3];
        logic          exp_d[3];

        wdata_pat = {8{32'hDEAD_BEEF}};
        rdata_pat = {8{32'hCAFE_F00D}};
        i_pmem_address = I_ADDR;
        d_pmem_address = D_ADDR;
        d_pmem_wdata   = wdata_pat;
        mem_rdata      = rdata_pat;

        // Reset held with every request and mem_resp high.
        rst_n = 1'b0;
        i_pmem_read = 1'b1; d_pmem_read = 1'b1; d_pmem_write = 1'b1; mem_resp = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        check("rst_mem_read", 64'(mem_read), 64'd0);
        check("rst_mem_write", 64'(mem_write), 64'd0);
        check("rst_mem_addr", 64'(mem_address), 64'd0);
        check_line("rst_mem_wdata", mem_wdata, '0);
        check("rst_resps", 64'({i_pmem_resp, d_pmem_resp}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_counts", 64'({i_grant_count, d_grant_count}), 64'd0);
        mem_resp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("first_contend_read", 64'(mem_read), 64'd1);
        check("first_contend_write", 64'(mem_write), 64'd0);
        check("first_contend_addr", 64'(mem_address), 64'(I_ADDR));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_read", 64'(mem_read), 64'd0);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;

        //            in       rw     addr     flg      ic    dc
        tbl[0]  = mk(4'b1100, 2'b00, 32'h0,    4'b0000, 4'd0, 4'd0);
        tbl[1]  = mk(4'b1100, 2'b10, I_ADDR,   4'b0001, 4'd0, 4'd0);
        tbl[2]  = mk(4'b1101, 2'b10, I_ADDR,   4'b0101, 4'd0, 4'd0);
        tbl[3]  = mk(4'b0100, 2'b00, 32'h0,    4'b0000, 4'd1, 4'd0);
        tbl[4]  = mk(4'b1100, 2'b10, D_ADDR,   4'b1001, 4'd1, 4'd0);
        tbl[5]  = mk(4'b1101, 2'b10, D_ADDR,   4'b1011, 4'd1, 4'd0);
        tbl[6]  = mk(4'b1000, 2'b00, 32'h0,    4'b0000, 4'd1, 4'd1);
        tbl[7]  = mk(4'b1011, 2'b10, I_ADDR,   4'b0101, 4'd1, 4'd1);
        tbl[8]  = mk(4'b0011, 2'b00, 32'h0,    4'b0000, 4'd2, 4'd1);
        tbl[9]  = mk(4'b0010, 2'b01, D_ADDR,   4'b1001, 4'd2, 4'd1);
        tbl[10] = mk(4'b0000, 2'b00, D_ADDR,   4'b1001, 4'd2, 4'd1);
        tbl[11] = mk(4'b0001, 2'b00, D_ADDR,   4'b1011, 4'd2, 4'd1);
        tbl[12] = mk(4'b0000, 2'b00, 32'h0,    4'b0000, 4'd2, 4'd2);
        tbl[13] = mk(4'b0001, 2'b00, 32'h0,    4'b0000, 4'd2, 4'd2);
        tbl[14] = mk(4'b0000, 2'b00, 32'h0,    4'b0000, 4'd2, 4'd2);

        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            {i_pmem_read, d_pmem_read, d_pmem_write, mem_resp} = tbl[n].in;
            #1;
            check($sformatf("v%0d_rw", n), 64'({mem_read, mem_write}), 64'(tbl[n].rw));
            check($sformatf("v%0d_addr", n), 64'(mem_address), 64'(tbl[n].addr));
            check_line($sformatf("v%0d_wdata", n), mem_wdata, tbl[n].flg[3] ? wdata_pat : '0);
            check($sformatf("v%0d_resp_busy", n), 64'({i_pmem_resp, d_pmem_resp, busy}), 64'(tbl[n].flg[2:0]));
            check($sformatf("v%0d_counts", n), 64'({i_grant_count, d_grant_count}), 64'({tbl[n].ic, tbl[n].dc}));
        end

        // Single icache read, memory answers after five waiting cycles.
        @(negedge clk);
        drive_idle();
        i_pmem_read = 1'b1;
        #1;
        check("iread_idle_nocmd", 64'({mem_read, busy}), 64'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            check("iread_wait", 64'({mem_read, mem_address, i_pmem_resp}), 64'({1'b1, I_ADDR, 1'b0}));
        end
        @(negedge clk);
        mem_resp = 1'b1;
        #1;
        check("iread_resp", 64'({i_pmem_resp, d_pmem_resp}), 64'b10);
        check_line("iread_rdata", i_pmem_rdata, rdata_pat);
        @(negedge clk);
        drive_idle();
        #1;
        check("iread_after", 64'({i_pmem_resp, busy, i_grant_count, d_grant_count}), 64'({2'b00, 4'd3, 4'd2}));

        // Write-back then refill with an icache read held throughout.
        i_rem = 1;
        dq.push_back('{wr: 1'b1, addr: 32'h0000_2000});
        dq.push_back('{wr: 1'b0, addr: 32'h0000_4000});
        run_traffic(100);
        exp_d[0] = 1'b1; exp_wr[0] = 1'b1; exp_addr[0] = 32'h0000_2000;
        exp_d[1] = 1'b0; exp_wr[1] = 1'b0; exp_addr[1] = I_ADDR;
        exp_d[2] = 1'b1; exp_wr[2] = 1'b0; exp_addr[2] = 32'h0000_4000;
        check("wb_refill_len", 64'(log_q.size()), 64'd3);
        for (int k = 0; k < log_q.size() && k < 3; k++)
            check($sformatf("wb_refill_%0d", k), 64'(log_q[k]), 64'({exp_d[k], exp_wr[k], exp_addr[k]}));
        check("wb_refill_counts", 64'({i_grant_count, d_grant_count}), 64'({4'd4, 4'd4}));

        // Eight contended transactions from a fresh reset must alternate I,D,...
        do_reset();
        i_rem = 4;
        for (int k = 0; k < 4; k++)
            dq.push_back('{wr: 1'b0, addr: 32'h0000_3000 + 32'(k * 32)});
        run_traffic(200);
        check("alt_len", 64'(log_q.size()), 64'd8);
        for (int k = 0; k < log_q.size() && k < 8; k++)
            check($sformatf("alt_%0d", k), 64'(log_q[k].is_d), 64'(k % 2));
        check("alt_counts", 64'({i_grant_count, d_grant_count}), 64'({4'd4, 4'd4}));

        // Asynchronous reset in the middle of a dcache write-back.
        @(negedge clk);
        d_pmem_write = 1'b1;
        d_pmem_address = D_ADDR;
        @(negedge clk); #1;
        check("midd_write", 64'({mem_write, busy}), 64'b11);
        #2 rst_n = 1'b0;
        #1;
        check("midd_rst", 64'({mem_write, mem_read, busy}), 64'd0);
        check("midd_rst_counts", 64'({i_grant_count, d_grant_count}), 64'd0);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;

        // Counter saturation at all-ones, then two more transactions.
        for (int k = 0; k < 15; k++)
            dq.push_back('{wr: 1'b1, addr: 32'h0000_8000 + 32'(k * 32)});
        run_traffic(300);
        check("sat_reach", 64'(d_grant_count), 64'(4'hF));
        dq.push_back('{wr: 1'b1, addr: 32'h0000_9000});
        dq.push_back('{wr: 1'b0, addr: 32'h0000_9020});
        run_traffic(100);
        check("sat_hold", 64'(d_grant_count), 64'(4'hF));
        check("sat_icount", 64'(i_grant_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
